inv_key_expansion: RTL and testbench
====================================

INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 SHALL have parameters: NUM_ROUNDS, default 10, number of AES-128 rounds; KEY_BYTES, default 16, round-key width in bytes.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have port start  input  1  request to begin a reverse schedule; sampled only in IDLE.
REQ-005 SHALL have port lastKey  input  128 (roundKey_t)  round-NUM_ROUNDS key; captured on an accepted start.
REQ-006 SHALL have port idle  output  1  high while in IDLE, ready to accept start.
REQ-007 SHALL have port keyValid  output  1  roundKey/roundNum hold a valid key.
REQ-008 SHALL have port keyAccept  input  1  downstream takes the key when keyValid && keyAccept at a rising edge.
REQ-009 SHALL have port roundKey  output  128 (roundKey_t)  current round key, word 0 in bits [127:96].
REQ-010 SHALL have port roundNum  output  4  index of roundKey: NUM_ROUNDS down to 0.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the round-0 key is accepted.

Function
REQ-012 SHALL implement FSM states IDLE, EMIT, FINISH.
REQ-013 IDLE: start=1 at edge -> capture lastKey into key register, roundNum=NUM_ROUNDS, go to EMIT; start=0 -> stay.
REQ-014 EMIT: keyValid=1; outputs SHALL hold stable while keyAccept=0 (stall, no limit).
REQ-015 EMIT, accept with roundNum>0: key register <= previous round key, roundNum <= roundNum-1, stay in EMIT; one key per cycle at full throughput.
REQ-016 EMIT, accept with roundNum==0: go to FINISH; keyValid=0 next cycle.
REQ-017 FINISH: done=1 for exactly one cycle, then IDLE unconditionally; start in FINISH SHALL be ignored.
REQ-018 start while EMIT or FINISH SHALL be ignored; lastKey changes while busy SHALL have no effect.
REQ-019 previous-key computation, current words w0..w3, round r: p3=w3^w2; p2=w2^w1; p1=w1^w0; p0=w0^SubWord(RotWord(p3))^Rcon[r]; combinational, registered on accept.
REQ-020 RotWord SHALL be a left byte rotation; Rcon[r] applies to the most significant byte only; Rcon[1..10]=01,02,04,08,10,20,40,80,1b,36.
REQ-021 latency: start edge -> keyValid high 1 cycle later; round-10 key SHALL equal lastKey unchanged.
REQ-022 idle=1 only in IDLE; keyValid=1 only in EMIT; done=1 only in FINISH.

Reset
REQ-023 reset assertion SHALL force IDLE, key register=0, roundNum=0, keyValid=0, done=0, idle=1 without waiting for a clock edge, including mid-schedule.
REQ-024 after reset deassertion the first accepted start SHALL produce a full schedule from round 10; no partial schedule resumes.

Structure
REQ-025 roundKey_t, NUM_ROUNDS, the Rcon table and the S-box function SHALL live in the shared AES definitions package; the same types SHALL be used by AddRoundKey.
REQ-026 SubWord SHALL be one sub-module, sub_word, four forward S-box lookups, 32-bit in/out, purely combinational.
REQ-027 no other sub-modules; FSM, key register and round counter in inv_key_expansion.

Verification
REQ-028 FIPS-197 A.1: start with lastKey=d014f9a8c9ee2589e13f0cc8b6630ca6, keyAccept=1 -> roundNum 10 key d014f9a8..., roundNum 9 key ac7766f319fadc2128d12941575c006e, ..., roundNum 0 key 2b7e151628aed2a6abf7158809cf4f3c; done pulses one cycle later.
REQ-029 stall: hold keyAccept=0 for 5 cycles at roundNum 7 -> roundKey/roundNum unchanged; resume -> round 6 key matches the k_sch vector for round 6.
REQ-030 busy start: pulse start with a different lastKey at roundNum 5 -> sequence continues unchanged to round 0.
REQ-031 reset mid-run: assert reset at roundNum 4, mid-cycle -> keyValid=0, idle=1 before the next edge; a new start restarts at round 10.
REQ-032 back-to-back: start held high through FINISH -> ignored in FINISH, accepted in the following IDLE cycle; the second schedule is complete and correct.
REQ-033 chaining: feed each roundKey with the matching k_sch state into AddRoundKey -> outputs match the decryption vectors from test/vectors/fips_example_vectors.txt.

Source files
------------

// File: rtl/inv_key_expansion_pkg.sv
// Shared AES-128 definitions: round-key type, round count, FSM state type,
// the Rcon table and the forward S-box lookup. Used by the reverse key
// schedule and by AddRoundKey.
package inv_key_expansion_pkg;

   localparam int NUM_ROUNDS = 10;
   localparam int KEY_BYTES  = 16;

   typedef logic [127:0] roundKey_t;
   typedef logic [31:0]  word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EMIT   = 2'd1,
      FINISH = 2'd2
   } ike_state_t;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Round constant for round r; 0 outside 1..10 (round 0 never derives a key).
   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/inv_key_expansion_sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word.
// Ports: word   - 32-bit input word
//        subbed - 32-bit output, each byte replaced by its S-box value
// Purely combinational.
module sub_word
   import inv_key_expansion_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] subbed
);

   for (genvar i = 0; i < 4; i++) begin : g_byte
      assign subbed[8*i +: 8] = sbox(word[8*i +: 8]);
   end

endmodule

// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule. Given the last round key, emits round keys
// from round NUM_ROUNDS down to round 0, one per accepted handshake.
// Ports: clock, reset (async, active-high)
//        start/lastKey    - begin a schedule from lastKey (taken only in IDLE)
//        idle             - ready to accept start
//        keyValid/keyAccept - valid/ready handshake on roundKey/roundNum
//        roundKey/roundNum  - current round key and its round index
//        done             - one-cycle pulse after the round-0 key is taken
module inv_key_expansion #(
   parameter int NUM_ROUNDS = inv_key_expansion_pkg::NUM_ROUNDS,
   parameter int KEY_BYTES  = inv_key_expansion_pkg::KEY_BYTES
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             start,
   input  inv_key_expansion_pkg::roundKey_t lastKey,
   output logic                             idle,
   output logic                             keyValid,
   input  logic                             keyAccept,
   output inv_key_expansion_pkg::roundKey_t roundKey,
   output logic [3:0]                       roundNum,
   output logic                             done
);
   import inv_key_expansion_pkg::*;

   ike_state_t            state_q, state_d;
   logic [KEY_BYTES*8-1:0] key_q;
   logic [3:0]            rnd_q;
   logic                  accept;

   word_t w0, w1, w2, w3;
   word_t p0, p1, p2, p3;
   word_t rot, subbed;

   // Undo one forward expansion step: the later words are XOR chains of the
   // earlier ones, and word 0 needs the g() function of the recovered word 3.
   assign w0  = key_q[127:96];
   assign w1  = key_q[95:64];
   assign w2  = key_q[63:32];
   assign w3  = key_q[31:0];
   assign p3  = w3 ^ w2;
   assign p2  = w2 ^ w1;
   assign p1  = w1 ^ w0;
   assign rot = {p3[23:0], p3[31:24]};

   sub_word u_sub_word (
      .word   (rot),
      .subbed (subbed)
   );

   assign p0 = w0 ^ subbed ^ {rcon(rnd_q), 24'h000000};

   assign accept = (state_q == EMIT) && keyAccept;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = EMIT;
         EMIT:    if (accept && (rnd_q == 4'd0)) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         key_q   <= '0;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) begin
            key_q <= lastKey;
            rnd_q <= 4'(NUM_ROUNDS);
         end else if (accept && (rnd_q != 4'd0)) begin
            key_q <= {p0, p1, p2, p3};
            rnd_q <= rnd_q - 4'd1;
         end
      end
   end

   assign idle     = (state_q == IDLE);
   assign keyValid = (state_q == EMIT);
   assign done     = (state_q == FINISH);
   assign roundKey = key_q;
   assign roundNum = rnd_q;

endmodule

// File: tb/tb_inv_key_expansion.sv
module tb_inv_key_expansion;
   import inv_key_expansion_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   roundKey_t  lastKey;
   logic       idle;
   logic       keyValid;
   logic       keyAccept;
   roundKey_t  roundKey;
   logic [3:0] roundNum;
   logic       done;

   int errors = 0;
   int checks = 0;
   int done_seen = 0;

   logic [131:0] exp_q[$];
   roundKey_t    ksch [0:10];

   inv_key_expansion #(.NUM_ROUNDS(10), .KEY_BYTES(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .lastKey   (lastKey),
      .idle      (idle),
      .keyValid  (keyValid),
      .keyAccept (keyAccept),
      .roundKey  (roundKey),
      .roundNum  (roundNum),
      .done      (done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every accepted key against the scoreboard.
   always @(negedge clock) begin
      if (!reset && done) done_seen++;
      if (!reset && keyValid && keyAccept) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_key: got rnd %0d key %h expected none", roundNum, roundKey);
         end else begin
            logic [131:0] e;
            e = exp_q.pop_front();
            if ({roundNum, roundKey} !== e) begin
               errors++;
               $display("FAIL key_r%0d: got rnd %0d key %h expected rnd %0d key %h",
                        e[131:128], roundNum, roundKey, e[131:128], e[127:0]);
            end
         end
      end
   end

   task automatic push_schedule();
      for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), ksch[r]});
   endtask

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clock);
         if (done) seen = 1;
      end
      chk({name, "_done"}, 128'(seen), 128'd1);
      if (seen) begin
         @(negedge clock);
         chk({name, "_done_width"}, 128'(done), 128'd0);
         chk({name, "_idle_after"}, 128'(idle), 128'd1);
      end
   endtask

   task automatic wait_round(input logic [3:0] r, output bit found);
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clock); #1;
         if (keyValid && roundNum == r) found = 1;
      end
      chk("wait_round", 128'(found), 128'd1);
   endtask

   task automatic issue_start(input roundKey_t k);
      @(posedge clock); #1;
      start   = 1'b1;
      lastKey = k;
      @(posedge clock); #1;
      start   = 1'b0;
   endtask

   initial begin
      bit found;
      ksch[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      ksch[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      ksch[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      ksch[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      ksch[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      ksch[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      ksch[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      ksch[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      ksch[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      ksch[9]  = 128'hac7766f319fadc2128d12941575c006e;
      ksch[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      reset = 1'b1; start = 1'b0; keyAccept = 1'b1; lastKey = '0;
      #1;
      chk("rst_idle", 128'(idle), 128'd1);
      chk("rst_keyValid", 128'(keyValid), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      chk("rst_roundNum", 128'(roundNum), 128'd0);
      chk("rst_roundKey", roundKey, 128'd0);
      @(posedge clock); #1; reset = 1'b0;

      // Full FIPS-197 A.1 reverse schedule at full throughput.
      push_schedule();
      issue_start(ksch[10]);
      wait_done("fips");
      chk("fips_drained", 128'(exp_q.size()), 128'd0);

      // Stall at round 7 for five cycles.
      push_schedule();
      issue_start(ksch[10]);
      wait_round(4'd7, found);
      keyAccept = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("stall_rnd", 128'(roundNum), 128'd7);
         chk("stall_key", roundKey, ksch[7]);
         chk("stall_valid", 128'(keyValid), 128'd1);
      end
      @(posedge clock); #1;
      keyAccept = 1'b1;
      wait_done("stall");
      chk("stall_drained", 128'(exp_q.size()), 128'd0);

      // Start with a different key while busy at round 5 must be ignored.
      push_schedule();
      issue_start(ksch[10]);
      wait_round(4'd5, found);
      start = 1'b1; lastKey = 128'h00112233445566778899aabbccddeeff;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done("busy");
      chk("busy_drained", 128'(exp_q.size()), 128'd0);

      // Asynchronous reset mid-schedule at round 4, then a clean restart.
      push_schedule();
      issue_start(ksch[10]);
      wait_round(4'd4, found);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_keyValid", 128'(keyValid), 128'd0);
      chk("mid_rst_idle", 128'(idle), 128'd1);
      chk("mid_rst_roundNum", 128'(roundNum), 128'd0);
      chk("mid_rst_roundKey", roundKey, 128'd0);
      exp_q.delete();
      @(posedge clock); #1; reset = 1'b0;
      push_schedule();
      issue_start(ksch[10]);
      wait_done("restart");
      chk("restart_drained", 128'(exp_q.size()), 128'd0);

      // Back-to-back: start held through FINISH; second schedule begins
      // only from the IDLE cycle after FINISH.
      push_schedule();
      push_schedule();
      @(posedge clock); #1;
      start = 1'b1; lastKey = ksch[10];
      wait_done("b2b_first");
      @(posedge clock); #1;
      chk("b2b_second_valid", 128'(keyValid), 128'd1);
      chk("b2b_second_rnd", 128'(roundNum), 128'd10);
      start = 1'b0;
      wait_done("b2b_second");
      chk("b2b_drained", 128'(exp_q.size()), 128'd0);

      @(negedge clock);
      chk("done_count", 128'(done_seen), 128'd6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
